// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   cnt_init / cnt_max : reset and saturation values of a CNT_W-bit direction counter
//   sat_update         : saturating increment/decrement of a direction counter
//   btb_entry_t        : one branch-target-buffer entry {valid, tag, target}
package bp_pkg;

  // Widest counter and tag the predictor supports; narrower fields are zero-extended.
  localparam int unsigned CntMaxW = 4;
  localparam int unsigned TagMaxW = 30;

  localparam logic [CntMaxW-1:0] CntOne = CntMaxW'(1);

  typedef struct packed {
    logic               valid;
    logic [TagMaxW-1:0] tag;
    logic [31:0]        target;
  } btb_entry_t;

  // Largest value of a w-bit counter.
  function automatic logic [CntMaxW-1:0] cnt_max(input int unsigned w);
    return CntMaxW'((32'd1 << w) - 32'd1);
  endfunction

  // Weakly not-taken: one below the taken threshold.
  function automatic logic [CntMaxW-1:0] cnt_init(input int unsigned w);
    return CntMaxW'((32'd1 << (w - 1)) - 32'd1);
  endfunction

  // Step a w-bit counter towards taken (up) or not-taken, holding at either end.
  function automatic logic [CntMaxW-1:0] sat_update(input logic [CntMaxW-1:0] cnt,
                                                    input logic               up,
                                                    input int unsigned        w);
    logic [CntMaxW-1:0] top;
    top = cnt_max(w);
    if (up) begin
      return (cnt == top) ? cnt : cnt + CntOne;
    end
    return (cnt == '0) ? cnt : cnt - CntOne;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating direction counters.
//   clk_i, rst_ni : clock, asynchronous active-low reset (counters -> weakly not-taken)
//   rd_idx_i      : asynchronous read index; rd_cnt_o returns that counter
//   wr_en_i       : commit a training step at the next rising edge
//   wr_idx_i      : counter to train; wr_up_i selects taken (up) or not-taken (down)
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned Entries = 64,
  parameter int unsigned CntW    = 2,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [CntW-1:0] rd_cnt_o,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic            wr_up_i
);

  localparam logic [CntW-1:0] CntInit = CntW'(cnt_init(CntW));

  logic [CntW-1:0] cnt_q [Entries];
  logic [CntW-1:0] wr_cnt;

  assign rd_cnt_o = cnt_q[rd_idx_i];

  // The write port carries a direction, so the read-modify-write of the trained
  // counter stays inside the table and the read port remains free for lookup.
  assign wr_cnt = CntW'(sat_update(CntMaxW'(cnt_q[wr_idx_i]), wr_up_i, CntW));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= CntInit;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor: tagged BTB plus a bimodal (GHR_W=0) or gshare (GHR_W>0) counter table.
//   CPU_CLK, CPU_RST_N        : clock, asynchronous active-low reset
//   PCF                       : fetch PC; PRED_TAKEN_F / PRED_TARGET_F / BTB_HIT_F /
//                               PRED_GHR_F are combinational from PCF and current state
//   UPD_VALID_E, PCE, BRANCH_E, BRNPC_E : resolved conditional branch in EX
//   PRED_TAKEN_E, PRED_TARGET_E, PRED_GHR_E : prediction piped down from IF
//   FLUSH_BTB                 : invalidate every BTB entry
//   MISPRED_E, CORRECT_NPC_E  : redirect request and the correct next PC
//   BR_COUNT, MISS_COUNT      : resolved-branch and misprediction statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned GHR_W   = 0,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                                   CPU_CLK,
  input  logic                                   CPU_RST_N,
  input  logic [31:0]                            PCF,
  output logic                                   PRED_TAKEN_F,
  output logic [31:0]                            PRED_TARGET_F,
  output logic                                   BTB_HIT_F,
  output logic [((GHR_W == 0) ? 1 : GHR_W)-1:0] PRED_GHR_F,
  input  logic                                   UPD_VALID_E,
  input  logic [31:0]                            PCE,
  input  logic                                   BRANCH_E,
  input  logic [31:0]                            BRNPC_E,
  input  logic                                   PRED_TAKEN_E,
  input  logic [31:0]                            PRED_TARGET_E,
  input  logic [((GHR_W == 0) ? 1 : GHR_W)-1:0] PRED_GHR_E,
  input  logic                                   FLUSH_BTB,
  output logic                                   MISPRED_E,
  output logic [31:0]                            CORRECT_NPC_E,
  output logic [31:0]                            BR_COUNT,
  output logic [31:0]                            MISS_COUNT
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned HIST_W = (GHR_W == 0) ? 1 : GHR_W;

  logic [HIST_W-1:0]  ghr_q, ghr_d;
  btb_entry_t         btb_q [ENTRIES];
  logic [31:0]        br_count_q, miss_count_q;

  logic [IDX_W-1:0]   pc_idx_f, pc_idx_e;
  logic [IDX_W-1:0]   hist_f, hist_e;
  logic [IDX_W-1:0]   lookup_idx, update_idx;
  logic [TagMaxW-1:0] tag_f, tag_e;
  btb_entry_t         entry_f;
  logic [CNT_W-1:0]   cnt_f;
  logic               hit_f;
  logic               taken_f;
  logic               mispred;

  // Bits of PC/PCE outside the index and tag fields are deliberately ignored.
  logic unused_pc;
  assign unused_pc = ^{PCF, PCE};

  assign pc_idx_f = PCF[IDX_W+1:2];
  assign pc_idx_e = PCE[IDX_W+1:2];
  assign tag_f    = TagMaxW'(PCF[IDX_W+2 +: TAG_W]);
  assign tag_e    = TagMaxW'(PCE[IDX_W+2 +: TAG_W]);

  if (GHR_W == 0) begin : g_bimodal
    logic unused_ghr_e;
    assign unused_ghr_e = ^PRED_GHR_E;
    assign hist_f = '0;
    assign hist_e = '0;
  end else begin : g_gshare
    assign hist_f = IDX_W'(ghr_q);
    assign hist_e = IDX_W'(PRED_GHR_E);
  end

  // Only the counter table sees history; the BTB is indexed by PC alone.
  assign lookup_idx = pc_idx_f ^ hist_f;
  assign update_idx = pc_idx_e ^ hist_e;

  bp_counter_table #(
    .Entries (ENTRIES),
    .CntW    (CNT_W),
    .IdxW    (IDX_W)
  ) u_counter_table (
    .clk_i    (CPU_CLK),
    .rst_ni   (CPU_RST_N),
    .rd_idx_i (lookup_idx),
    .rd_cnt_o (cnt_f),
    .wr_en_i  (UPD_VALID_E),
    .wr_idx_i (update_idx),
    .wr_up_i  (BRANCH_E)
  );

  // Lookup: no bypass from a same-cycle update.
  assign entry_f = btb_q[pc_idx_f];
  assign hit_f   = entry_f.valid && (entry_f.tag == tag_f);
  assign taken_f = hit_f && cnt_f[CNT_W-1];

  assign BTB_HIT_F     = hit_f;
  assign PRED_TAKEN_F  = taken_f;
  assign PRED_TARGET_F = taken_f ? entry_f.target : PCF + 32'd4;
  assign PRED_GHR_F    = ghr_q;

  assign mispred = UPD_VALID_E &
                   ((BRANCH_E != PRED_TAKEN_E) | (BRANCH_E & (PRED_TARGET_E != BRNPC_E)));

  assign MISPRED_E     = mispred;
  assign CORRECT_NPC_E = BRANCH_E ? BRNPC_E : PCE + 32'd4;
  assign BR_COUNT      = br_count_q;
  assign MISS_COUNT    = miss_count_q;

  // History is trained at resolve only; in bimodal mode it stays at zero.
  always_comb begin
    ghr_d = ghr_q;
    if (UPD_VALID_E && (GHR_W != 0)) begin
      ghr_d = HIST_W'({ghr_q, BRANCH_E});
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      ghr_q        <= '0;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (UPD_VALID_E) begin
        br_count_q <= br_count_q + 32'd1;
        if (mispred) begin
          miss_count_q <= miss_count_q + 32'd1;
        end
      end
    end
  end

  // A taken update is written after the flush so its entry survives a same-cycle flush.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else begin
      if (FLUSH_BTB) begin
        for (int i = 0; i < ENTRIES; i++) begin
          btb_q[i].valid <= 1'b0;
        end
      end
      if (UPD_VALID_E && BRANCH_E) begin
        btb_q[pc_idx_e] <= '{valid: 1'b1, tag: tag_e, target: BRNPC_E};
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic clk;
  logic rst_n;

  // Index 0: bimodal instance (GHR_W=0); index 1: gshare instance (GHR_W=4).
  logic [31:0] pcf [2];
  logic        pred_taken_f [2];
  logic [31:0] pred_target_f [2];
  logic        btb_hit_f [2];
  logic        upd_valid [2];
  logic [31:0] pce [2];
  logic        branch_e [2];
  logic [31:0] brnpc_e [2];
  logic        pred_taken_e [2];
  logic [31:0] pred_target_e [2];
  logic        flush_btb [2];
  logic        mispred_e [2];
  logic [31:0] correct_npc [2];
  logic [31:0] br_count [2];
  logic [31:0] miss_count [2];
  logic        ghr_f_b, ghr_e_b;
  logic [3:0]  ghr_f_g, ghr_e_g;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain arrays of integers per instance.
  int          mcnt  [2][64];
  bit          mvalid[2][64];
  int          mtag  [2][64];
  logic [31:0] mtgt  [2][64];
  int          mghr  [2];
  logic [31:0] mbr   [2];
  logic [31:0] mmiss [2];

  branch_predictor #(
    .ENTRIES (64), .CNT_W (2), .GHR_W (0), .TAG_W (8)
  ) dut_bi (
    .CPU_CLK       (clk),
    .CPU_RST_N     (rst_n),
    .PCF           (pcf[0]),
    .PRED_TAKEN_F  (pred_taken_f[0]),
    .PRED_TARGET_F (pred_target_f[0]),
    .BTB_HIT_F     (btb_hit_f[0]),
    .PRED_GHR_F    (ghr_f_b),
    .UPD_VALID_E   (upd_valid[0]),
    .PCE           (pce[0]),
    .BRANCH_E      (branch_e[0]),
    .BRNPC_E       (brnpc_e[0]),
    .PRED_TAKEN_E  (pred_taken_e[0]),
    .PRED_TARGET_E (pred_target_e[0]),
    .PRED_GHR_E    (ghr_e_b),
    .FLUSH_BTB     (flush_btb[0]),
    .MISPRED_E     (mispred_e[0]),
    .CORRECT_NPC_E (correct_npc[0]),
    .BR_COUNT      (br_count[0]),
    .MISS_COUNT    (miss_count[0])
  );

  branch_predictor #(
    .ENTRIES (64), .CNT_W (2), .GHR_W (4), .TAG_W (8)
  ) dut_gs (
    .CPU_CLK       (clk),
    .CPU_RST_N     (rst_n),
    .PCF           (pcf[1]),
    .PRED_TAKEN_F  (pred_taken_f[1]),
    .PRED_TARGET_F (pred_target_f[1]),
    .BTB_HIT_F     (btb_hit_f[1]),
    .PRED_GHR_F    (ghr_f_g),
    .UPD_VALID_E   (upd_valid[1]),
    .PCE           (pce[1]),
    .BRANCH_E      (branch_e[1]),
    .BRNPC_E       (brnpc_e[1]),
    .PRED_TAKEN_E  (pred_taken_e[1]),
    .PRED_TARGET_E (pred_target_e[1]),
    .PRED_GHR_E    (ghr_e_g),
    .FLUSH_BTB     (flush_btb[1]),
    .MISPRED_E     (mispred_e[1]),
    .CORRECT_NPC_E (correct_npc[1]),
    .BR_COUNT      (br_count[1]),
    .MISS_COUNT    (miss_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) begin
        mcnt[k][i]   = 1;
        mvalid[k][i] = 1'b0;
        mtag[k][i]   = 0;
        mtgt[k][i]   = 32'h0;
      end
      mghr[k]  = 0;
      mbr[k]   = 32'h0;
      mmiss[k] = 32'h0;
    end
  endfunction

  function automatic void m_lookup(input int k, input logic [31:0] pc, output logic taken,
                                   output logic [31:0] tgt, output logic hit);
    int idx, li;
    idx   = int'((pc >> 2) & 32'd63);
    li    = (k == 1) ? (idx ^ mghr[k]) : idx;
    hit   = mvalid[k][idx] && (mtag[k][idx] == int'((pc >> 8) & 32'd255));
    taken = hit && (mcnt[k][li] >= 2);
    tgt   = taken ? mtgt[k][idx] : pc + 32'd4;
  endfunction

  function automatic void m_update(input int k, input logic [31:0] pc, input logic br,
                                   input logic [31:0] tgt, input logic mis,
                                   input int ghr_snap, input logic fl);
    int idx, ui;
    idx = int'((pc >> 2) & 32'd63);
    ui  = (k == 1) ? (idx ^ ghr_snap) : idx;
    if (br) mcnt[k][ui] = (mcnt[k][ui] < 3) ? mcnt[k][ui] + 1 : 3;
    else    mcnt[k][ui] = (mcnt[k][ui] > 0) ? mcnt[k][ui] - 1 : 0;
    if (fl) begin
      for (int i = 0; i < 64; i++) mvalid[k][i] = 1'b0;
    end
    if (br) begin
      mvalid[k][idx] = 1'b1;
      mtag[k][idx]   = int'((pc >> 8) & 32'd255);
      mtgt[k][idx]   = tgt;
    end
    if (k == 1) mghr[k] = ((mghr[k] << 1) | int'(br)) & 15;
    mbr[k] = mbr[k] + 32'd1;
    if (mis) mmiss[k] = mmiss[k] + 32'd1;
  endfunction

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      pcf[k] = 32'h0; upd_valid[k] = 1'b0; pce[k] = 32'h0; branch_e[k] = 1'b0;
      brnpc_e[k] = 32'h0; pred_taken_e[k] = 1'b0; pred_target_e[k] = 32'h0;
      flush_btb[k] = 1'b0;
    end
    ghr_e_b = 1'b0;
    ghr_e_g = 4'h0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  // Fetch-only lookup compared against the model.
  task automatic lookup(input int k, input logic [31:0] pc);
    logic e_taken, e_hit;
    logic [31:0] e_tgt;
    @(negedge clk);
    pcf[k] = pc;
    #1;
    m_lookup(k, pc, e_taken, e_tgt, e_hit);
    n_checks++;
    if (pred_taken_f[k] !== e_taken)
      $display("FAIL lookup_taken[%0d] pc=%h: got %b want %b", k, pc, pred_taken_f[k], e_taken);
    else n_pass++;
    n_checks++;
    if (pred_target_f[k] !== e_tgt)
      $display("FAIL lookup_target[%0d] pc=%h: got %h want %h", k, pc, pred_target_f[k], e_tgt);
    else n_pass++;
    n_checks++;
    if (btb_hit_f[k] !== e_hit)
      $display("FAIL lookup_hit[%0d] pc=%h: got %b want %b", k, pc, btb_hit_f[k], e_hit);
    else n_pass++;
  endtask

  // Fetch at pc and resolve the same branch in the same cycle, EX fed from the model's
  // prediction; checks lookup, redirect and statistics against the model.
  task automatic do_branch(input int k, input logic [31:0] pc, input logic br,
                           input logic [31:0] tgt, input logic fl,
                           output logic got_taken, output logic [31:0] got_tgt,
                           output logic got_mis);
    logic        e_taken, e_hit, e_mis;
    logic [31:0] e_tgt, e_npc;
    logic [3:0]  obs_ghr;
    int          snap;
    @(negedge clk);
    pcf[k] = pc;
    #1;
    m_lookup(k, pc, e_taken, e_tgt, e_hit);
    snap      = mghr[k];
    got_taken = pred_taken_f[k];
    got_tgt   = pred_target_f[k];
    obs_ghr   = (k == 0) ? {3'b000, ghr_f_b} : ghr_f_g;
    n_checks++;
    if (got_taken !== e_taken)
      $display("FAIL br_taken[%0d] pc=%h: got %b want %b", k, pc, got_taken, e_taken);
    else n_pass++;
    n_checks++;
    if (got_tgt !== e_tgt)
      $display("FAIL br_target[%0d] pc=%h: got %h want %h", k, pc, got_tgt, e_tgt);
    else n_pass++;
    n_checks++;
    if (btb_hit_f[k] !== e_hit)
      $display("FAIL br_hit[%0d] pc=%h: got %b want %b", k, pc, btb_hit_f[k], e_hit);
    else n_pass++;
    n_checks++;
    if (obs_ghr !== 4'(snap))
      $display("FAIL ghr[%0d]: got %h want %h", k, obs_ghr, 4'(snap));
    else n_pass++;

    upd_valid[k] = 1'b1; pce[k] = pc; branch_e[k] = br; brnpc_e[k] = tgt;
    pred_taken_e[k] = e_taken; pred_target_e[k] = e_tgt; flush_btb[k] = fl;
    if (k == 0) ghr_e_b = 1'b0;
    else        ghr_e_g = 4'(snap);
    #1;
    e_mis   = (br != e_taken) || (br && (e_tgt != tgt));
    e_npc   = br ? tgt : pc + 32'd4;
    got_mis = mispred_e[k];
    n_checks++;
    if (got_mis !== e_mis)
      $display("FAIL mispred[%0d] pc=%h: got %b want %b", k, pc, got_mis, e_mis);
    else n_pass++;
    n_checks++;
    if (correct_npc[k] !== e_npc)
      $display("FAIL correct_npc[%0d] pc=%h: got %h want %h", k, pc, correct_npc[k], e_npc);
    else n_pass++;

    @(posedge clk);
    m_update(k, pc, br, tgt, e_mis, snap, fl);
    #1;
    upd_valid[k] = 1'b0;
    flush_btb[k] = 1'b0;
    n_checks++;
    if (br_count[k] !== mbr[k])
      $display("FAIL br_count[%0d]: got %0d want %0d", k, br_count[k], mbr[k]);
    else n_pass++;
    n_checks++;
    if (miss_count[k] !== mmiss[k])
      $display("FAIL miss_count[%0d]: got %0d want %0d", k, miss_count[k], mmiss[k]);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      lookup(k, 32'h100);
      n_checks++;
      if (pred_taken_f[k] !== 1'b0 || pred_target_f[k] !== 32'h104 || btb_hit_f[k] !== 1'b0)
        $display("FAIL reset_pred[%0d]: got %b/%h/%b want 0/00000104/0", k,
                 pred_taken_f[k], pred_target_f[k], btb_hit_f[k]);
      else n_pass++;
      n_checks++;
      if (br_count[k] !== 32'h0 || miss_count[k] !== 32'h0)
        $display("FAIL reset_counts[%0d]: got %0d/%0d want 0/0", k, br_count[k], miss_count[k]);
      else n_pass++;
    end
    // Reset asserted while an update is pending must discard it.
    @(negedge clk);
    upd_valid[0] = 1'b1; pce[0] = 32'h200; branch_e[0] = 1'b1; brnpc_e[0] = 32'h80;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 upd_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lookup(0, 32'h200);
    n_checks++;
    if (br_count[0] !== 32'h0 || btb_hit_f[0] !== 1'b0)
      $display("FAIL reset_mid_update: got count %0d hit %b want 0/0", br_count[0], btb_hit_f[0]);
    else n_pass++;
  endtask

  task automatic test_bimodal_train();
    logic t, m, m_first;
    logic [31:0] g;
    do_reset();
    do_branch(0, 32'h200, 1'b1, 32'h80, 1'b0, t, g, m_first);
    n_checks++;
    if (m_first !== 1'b1) $display("FAIL train_first_mispred: got %b want 1", m_first);
    else n_pass++;
    do_branch(0, 32'h200, 1'b1, 32'h80, 1'b0, t, g, m);
    do_branch(0, 32'h200, 1'b1, 32'h80, 1'b0, t, g, m);
    lookup(0, 32'h200);
    n_checks++;
    if (pred_taken_f[0] !== 1'b1 || pred_target_f[0] !== 32'h80)
      $display("FAIL train_predict: got %b/%h want 1/00000080", pred_taken_f[0], pred_target_f[0]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic t, m;
    logic [31:0] g;
    do_branch(0, 32'h200, 1'b1, 32'h80, 1'b0, t, g, m);
    do_branch(0, 32'h200, 1'b0, 32'h80, 1'b0, t, g, m);
    lookup(0, 32'h200);
    n_checks++;
    if (pred_taken_f[0] !== 1'b1)
      $display("FAIL sat_one_not_taken: got %b want 1", pred_taken_f[0]);
    else n_pass++;
    do_branch(0, 32'h200, 1'b0, 32'h80, 1'b0, t, g, m);
    lookup(0, 32'h200);
    n_checks++;
    if (pred_taken_f[0] !== 1'b0 || pred_target_f[0] !== 32'h204)
      $display("FAIL sat_two_not_taken: got %b/%h want 0/00000204",
               pred_taken_f[0], pred_target_f[0]);
    else n_pass++;
  endtask

  task automatic test_tag_conflict();
    logic t, m;
    logic [31:0] g;
    do_branch(0, 32'h200, 1'b1, 32'h80, 1'b0, t, g, m);
    do_branch(0, 32'h300, 1'b1, 32'h90, 1'b0, t, g, m);
    lookup(0, 32'h200);
    n_checks++;
    if (btb_hit_f[0] !== 1'b0 || pred_taken_f[0] !== 1'b0)
      $display("FAIL tag_conflict: got hit %b taken %b want 0/0", btb_hit_f[0], pred_taken_f[0]);
    else n_pass++;
  endtask

  task automatic test_flush_simultaneous();
    logic t, m;
    logic [31:0] g;
    do_reset();
    do_branch(0, 32'h104, 1'b1, 32'h20, 1'b0, t, g, m);
    do_branch(0, 32'h108, 1'b1, 32'h30, 1'b0, t, g, m);
    do_branch(0, 32'h108, 1'b1, 32'h30, 1'b0, t, g, m);
    do_branch(0, 32'h108, 1'b1, 32'h40, 1'b1, t, g, m);
    n_checks++;
    if (t !== 1'b1 || g !== 32'h30)
      $display("FAIL flush_same_cycle_lookup: got %b/%h want 1/00000030", t, g);
    else n_pass++;
    lookup(0, 32'h104);
    n_checks++;
    if (btb_hit_f[0] !== 1'b0) $display("FAIL flush_other_entry: got hit %b want 0", btb_hit_f[0]);
    else n_pass++;
    lookup(0, 32'h108);
    n_checks++;
    if (btb_hit_f[0] !== 1'b1 || pred_target_f[0] !== 32'h40)
      $display("FAIL flush_updated_entry: got %b/%h want 1/00000040",
               btb_hit_f[0], pred_target_f[0]);
    else n_pass++;
  endtask

  task automatic test_gshare();
    logic t, m;
    logic [31:0] g, miss0, br0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_branch(1, 32'h400, (i % 2 == 0), 32'h800, 1'b0, t, g, m);
    end
    miss0 = mmiss[1];
    br0   = mbr[1];
    for (int i = 16; i < 32; i++) begin
      do_branch(1, 32'h400, (i % 2 == 0), 32'h800, 1'b0, t, g, m);
      n_checks++;
      if (m !== 1'b0) $display("FAIL gshare_steady_mispred iter %0d: got %b want 0", i, m);
      else n_pass++;
    end
    n_checks++;
    if (miss_count[1] !== miss0 || br_count[1] !== br0 + 32'd16)
      $display("FAIL gshare_counts: got %0d/%0d want %0d/%0d",
               miss_count[1], br_count[1], miss0, br0 + 32'd16);
    else n_pass++;
  endtask

  task automatic test_random();
    logic t, m, br, fl;
    logic [31:0] g, pc, tgt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pc  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      tgt = 32'h1000 | (32'($urandom_range(0, 3)) << 4);
      br  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      do_branch(i % 2, pc, br, tgt, fl, t, g, m);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    m_reset();
    test_reset();
    test_bimodal_train();
    test_saturation();
    test_tag_conflict();
    test_flush_simultaneous();
    test_gshare();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
